// File: rtl/timer_arb_pkg.sv
// Shared types and the round-robin pick function for the timer arbiter.
// Optional abort-on-request-drop is selected with TIMER_ARB_ABORT_EN in timer_arbiter.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int MAX_REQ = 32;

  // The scan runs from the farthest offset down to the nearest, so the last hit is the nearest set req.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int idx;
    int win;
    win = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/timer_arbiter_tick_gen.sv
// Prescaler producing one unit_tick every PRESCALE clk cycles; clear restarts the count at zero.
// When PRESCALE is 1, unit_tick is held high.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic unit_tick
);

  generate
    if (PRESCALE == 1) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, clear};
      assign unit_tick  = 1'b1;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] presc_q;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          presc_q <= '0;
        end else if (presc_q == PW'(PRESCALE - 1)) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end

      assign unit_tick = (presc_q == PW'(PRESCALE - 1));
    end
  endgenerate

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin shared delay timer: one down-counter granted to one requester at a time.
// Define TIMER_ARB_ABORT_EN to let an owner cancel its wait by dropping req during RUN.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;

  logic                 unit_tick;
  logic                 tick_clear;
  logic                 abort;
  logic [MAX_REQ-1:0]   req_ext;
  logic [PTR_W-1:0]     winner;
  logic [CNT_W-1:0]     win_delay;
  logic [PTR_W-1:0]     rr_ptr_d;

  // Prescaler only runs in RUN, so every grant starts with a fresh full unit.
  assign tick_clear = (state_q != ST_RUN);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (tick_clear),
    .unit_tick(unit_tick)
  );

  assign req_ext = MAX_REQ'(req);

`ifdef TIMER_ARB_ABORT_EN
  assign abort = !req[owner_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    winner    = PTR_W'(rr_pick(req_ext, int'(rr_ptr_q), NUM_REQ));
    win_delay = delay[winner*CNT_W +: CNT_W];
    rr_ptr_d  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_RUN;
            owner_q <= winner;
            grant_q <= NUM_REQ'(1) << winner;
            cnt_q   <= (win_delay == '0) ? CNT_W'(1) : win_delay;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end else if (unit_tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= grant_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          rr_ptr_q <= rr_ptr_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: one instance with PRESCALE=1, one with PRESCALE=3.
// Abort expectations follow TIMER_ARB_ABORT_EN.
module tb_timer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req3;
  logic [63:0] delay, delay3;
  logic [3:0]  grant, done, grant3, done3;
  logic        busy, busy3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(4), .CNT_W(16), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .delay(delay),
    .grant(grant), .done(done), .busy(busy)
  );

  timer_arbiter #(.NUM_REQ(4), .CNT_W(16), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .delay(delay3),
    .grant(grant3), .done(done3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    req3  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] exp_d;

    reset  = 1'b1;
    req    = '0;
    req3   = '0;
    delay  = '0;
    delay3 = '0;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant3", 32'(grant3), 32'h0);
    chk("rst_busy3", 32'(busy3), 32'h0);
    reset = 1'b0;

    // single request, delay 5
    req = 4'b0100;
    delay[32 +: 16] = 16'd5;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_d = (k == 6) ? 4'b0100 : 4'b0000;
      chk("single_grant", 32'(grant), 32'(4'b0100));
      chk("single_done", 32'(done), 32'(exp_d));
      chk("single_busy", 32'(busy), 32'h1);
      if (k == 6) req = '0;
    end
    step();
    chk("single_idle_grant", 32'(grant), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_done", 32'(done), 32'h0);

    // zero delay with PRESCALE=3
    req3 = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_d = (k == 4) ? 4'b0010 : 4'b0000;
      chk("zero_grant", 32'(grant3), 32'(4'b0010));
      chk("zero_done", 32'(done3), 32'(exp_d));
      if (k == 4) req3 = '0;
    end
    step();
    chk("zero_idle_grant", 32'(grant3), 32'h0);
    chk("zero_idle_busy", 32'(busy3), 32'h0);

    // round-robin fairness
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) delay[i*16 +: 16] = 16'd2;
    for (int r = 0; r < 4; r++) begin
      exp_g = 4'b0001 << r;
      for (int k = 1; k <= 3; k++) begin
        step();
        exp_d = (k == 3) ? exp_g : 4'b0000;
        chk("rr_grant", 32'(grant), 32'(exp_g));
        chk("rr_done", 32'(done), 32'(exp_d));
        if (k == 3) req[r] = 1'b0;
      end
      step();
      chk("rr_gap_busy", 32'(busy), 32'h0);
      chk("rr_gap_grant", 32'(grant), 32'h0);
    end

    // re-request goes to lowest priority
    do_reset();
    req = 4'b1001;
    delay[0 +: 16]  = 16'd1;
    delay[48 +: 16] = 16'd1;
    step(); chk("rereq_g0", 32'(grant), 32'(4'b0001));
    step(); chk("rereq_d0", 32'(done), 32'(4'b0001));
    step(); chk("rereq_gap0", 32'(busy), 32'h0);
    step(); chk("rereq_g3", 32'(grant), 32'(4'b1000));
    step(); chk("rereq_d3", 32'(done), 32'(4'b1000));
    req[3] = 1'b0;
    step(); chk("rereq_gap3", 32'(busy), 32'h0);
    step(); chk("rereq_g0b", 32'(grant), 32'(4'b0001));
    step(); chk("rereq_d0b", 32'(done), 32'(4'b0001));
    req = '0;
    step(); chk("rereq_idle", 32'(busy), 32'h0);

    // reset mid-RUN with rr pointer away from zero
    req = 4'b0010;
    delay[16 +: 16] = 16'd10;
    step(); chk("midrst_grant", 32'(grant), 32'(4'b0010));
    step();
    step(); chk("midrst_grant2", 32'(grant), 32'(4'b0010));
    chk("midrst_nodone", 32'(done), 32'h0);
    reset = 1'b1;
    step();
    chk("midrst_grant_clr", 32'(grant), 32'h0);
    chk("midrst_busy_clr", 32'(busy), 32'h0);
    chk("midrst_done_clr", 32'(done), 32'h0);
    reset = 1'b0;
    req = 4'b0011;
    step(); chk("midrst_ptr0", 32'(grant), 32'(4'b0001));
    step(); chk("midrst_after_done", 32'(done), 32'(4'b0001));
    req = '0;
    step();

    // owner drops req mid-RUN
    do_reset();
    req = 4'b0100;
    delay[32 +: 16] = 16'd4;
    step(); chk("abort_grant1", 32'(grant), 32'(4'b0100));
    step(); chk("abort_grant2", 32'(grant), 32'(4'b0100));
    req = '0;
    step();
`ifdef TIMER_ARB_ABORT_EN
    chk("abort_grant_clr", 32'(grant), 32'h0);
    chk("abort_busy_clr", 32'(busy), 32'h0);
    chk("abort_nodone", 32'(done), 32'h0);
    step();
    step(); chk("abort_nodone_late", 32'(done), 32'h0);
`else
    chk("noabort_grant", 32'(grant), 32'(4'b0100));
    chk("noabort_busy", 32'(busy), 32'h1);
    step();
    step(); chk("noabort_done", 32'(done), 32'(4'b0100));
`endif
    step();
    chk("abort_end_busy", 32'(busy), 32'h0);
    chk("abort_end_grant", 32'(grant), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
